// File: rtl/alu_pkg.sv
// alu_pkg
//   Shared definitions for the sequential ALU: the 4-bit operation
//   encoding, the controller state encoding and a helper that sizes the
//   iteration counter for a given operand width.
package alu_pkg;

    // Operation codes. sel[3]=0 is the arithmetic group, sel[3]=1 the
    // bitwise logic group. 4'b0101..4'b0111 are deliberately unnamed and
    // are reported as illegal by the top level.
    typedef enum logic [3:0] {
        OP_ADD  = 4'b0000,
        OP_SUB  = 4'b0001,
        OP_MUL  = 4'b0010,
        OP_DIV  = 4'b0011,
        OP_MOD  = 4'b0100,
        OP_AND  = 4'b1000,
        OP_OR   = 4'b1001,
        OP_XOR  = 4'b1010,
        OP_NOTA = 4'b1011,
        OP_NOTB = 4'b1100,
        OP_NAND = 4'b1101,
        OP_NOR  = 4'b1110,
        OP_XNOR = 4'b1111
    } op_t;

    // Controller states: waiting for work, iterating, holding a result.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        HOLD = 2'd2
    } state_t;

    // The counter must be able to hold the value W itself, hence the +1.
    function automatic int cntWidth(input int w);
        return $clog2(w) + 1;
    endfunction

endpackage

// File: rtl/alu_iter_core.sv
// alu_iter_core
//   Iterative engine shared by MUL, DIV and MOD. MUL is a shift-add over a
//   2W-bit accumulator (one multiplier bit per cycle, LSB first). DIV/MOD
//   is restoring division with a (W+1)-bit trial remainder, producing one
//   quotient bit per cycle from the MSB of the dividend down.
//
// Ports
//   clk, rst_n   : clock, asynchronous active-low reset
//   i_load       : capture operands and start a W-step run
//   i_step       : perform one iteration this cycle
//   i_isDiv      : run mode captured on load (1 = divide, 0 = multiply)
//   i_a, i_b     : operands (a = multiplicand / dividend, b = multiplier / divisor)
//   o_finished   : the step performed this cycle is the last one
//   o_result     : value after this cycle's step; {remainder, quotient}
//                  in divide mode, the full product in multiply mode
module alu_iter_core
    import alu_pkg::*;
#(
    parameter int W = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           i_load,
    input  logic           i_step,
    input  logic           i_isDiv,
    input  logic [W-1:0]   i_a,
    input  logic [W-1:0]   i_b,
    output logic           o_finished,
    output logic [2*W-1:0] o_result
);

    localparam int CW = cntWidth(W);

    logic [CW-1:0]  r_count;
    logic           r_isDiv;
    logic [2*W-1:0] r_acc;
    // Multiplicand shifted left each step, or the divisor in its low W bits.
    logic [2*W-1:0] r_opnd;
    // Multiplier shifted right each step, or dividend bits shifted out at
    // the top while quotient bits shift in at the bottom.
    logic [W-1:0]   r_shift;
    logic [W-1:0]   r_rem;

    logic [2*W-1:0] w_accNext;
    logic [W:0]     w_trial;
    logic [W:0]     w_diff;
    logic [W-1:0]   w_remNext;
    logic [W-1:0]   w_quotNext;

    // Next-step values for both modes. A set MSB on the difference means
    // the trial remainder was smaller than the divisor, so it is restored.
    always_comb begin
        w_accNext  = r_acc + (r_shift[0] ? r_opnd : '0);
        w_trial    = {r_rem, r_shift[W-1]};
        w_diff     = w_trial - {1'b0, r_opnd[W-1:0]};
        w_remNext  = w_diff[W] ? w_trial[W-1:0] : w_diff[W-1:0];
        w_quotNext = {r_shift[W-2:0], ~w_diff[W]};
    end

    assign o_finished = (r_count == CW'(1));
    assign o_result   = r_isDiv ? {w_remNext, w_quotNext} : w_accNext;

    // Load seeds the registers for the selected mode; each step advances
    // the run until the counter is exhausted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
            r_isDiv <= 1'b0;
            r_acc   <= '0;
            r_opnd  <= '0;
            r_shift <= '0;
            r_rem   <= '0;
        end else if (i_load) begin
            r_count <= CW'(W);
            r_isDiv <= i_isDiv;
            r_acc   <= '0;
            r_rem   <= '0;
            if (i_isDiv) begin
                r_opnd  <= {{W{1'b0}}, i_b};
                r_shift <= i_a;
            end else begin
                r_opnd  <= {{W{1'b0}}, i_a};
                r_shift <= i_b;
            end
        end else if (i_step && (r_count != '0)) begin
            r_count <= r_count - CW'(1);
            if (r_isDiv) begin
                r_rem   <= w_remNext;
                r_shift <= w_quotNext;
            end else begin
                r_acc   <= w_accNext;
                r_opnd  <= r_opnd << 1;
                r_shift <= r_shift >> 1;
            end
        end
    end

endmodule

// File: rtl/alu_seq.sv
// alu_seq
//   Multi-cycle ALU for the execute stage. One operation is accepted at a
//   time; single-step ops resolve on the accept edge, MUL/DIV/MOD run in
//   alu_iter_core for W cycles. The result is held until consumed.
//
// Ports
//   clk, rst_n    : clock, asynchronous active-low reset
//   i_in_valid    : request present          o_in_ready  : request accepted when high
//   i_a, i_b      : unsigned operands         i_sel       : operation code (op_t)
//   o_out_valid   : result held               i_out_ready : consumer takes the result
//   o_out         : 2W-bit result
//   o_div_zero    : held result is a div/mod by zero
//   o_illegal     : held result came from an unused opcode
module alu_seq
    import alu_pkg::*;
#(
    parameter int W = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           i_in_valid,
    output logic           o_in_ready,
    input  logic [W-1:0]   i_a,
    input  logic [W-1:0]   i_b,
    input  logic [3:0]     i_sel,
    output logic           o_out_valid,
    input  logic           i_out_ready,
    output logic [2*W-1:0] o_out,
    output logic           o_div_zero,
    output logic           o_illegal
);

    state_t         r_state;
    logic           r_inReady;
    logic           r_outValid;
    logic [2*W-1:0] r_out;
    logic           r_divZero;
    logic           r_illegal;
    logic           r_isMod;

    op_t            w_op;
    logic [W:0]     w_sum;
    logic [2*W-1:0] w_single;
    logic           w_illegalOp;
    logic           w_isIter;
    logic           w_isDiv;
    logic           w_isMod;
    logic           w_divZero;
    logic           w_accept;
    logic           w_load;
    logic           w_step;
    logic           w_finished;
    logic [2*W-1:0] w_iterResult;

    assign w_op  = op_t'(i_sel);
    assign w_sum = {1'b0, i_a} + {1'b0, i_b};

    // Single-step datapath, decoded straight from the request inputs so the
    // result can be registered on the accept edge. For DIV/MOD, w_single
    // carries the divide-by-zero answer, which is only used when b is 0.
    always_comb begin
        w_single    = '0;
        w_illegalOp = 1'b0;
        w_isIter    = 1'b0;
        w_isDiv     = 1'b0;
        w_isMod     = 1'b0;
        case (w_op)
            OP_ADD:  w_single = {{(W-1){1'b0}}, w_sum};
            OP_SUB:  w_single = {{W{1'b0}}, i_a} - {{W{1'b0}}, i_b};
            OP_MUL:  w_isIter = 1'b1;
            OP_DIV: begin
                w_isIter = 1'b1;
                w_isDiv  = 1'b1;
                w_single = {i_a, {W{1'b1}}};
            end
            OP_MOD: begin
                w_isIter = 1'b1;
                w_isDiv  = 1'b1;
                w_isMod  = 1'b1;
                w_single = {{W{1'b0}}, i_a};
            end
            OP_AND:  w_single = {{W{1'b0}}, i_a & i_b};
            OP_OR:   w_single = {{W{1'b0}}, i_a | i_b};
            OP_XOR:  w_single = {{W{1'b0}}, i_a ^ i_b};
            OP_NOTA: w_single = {{W{1'b0}}, ~i_a};
            OP_NOTB: w_single = {{W{1'b0}}, ~i_b};
            OP_NAND: w_single = {{W{1'b0}}, ~(i_a & i_b)};
            OP_NOR:  w_single = {{W{1'b0}}, ~(i_a | i_b)};
            OP_XNOR: w_single = {{W{1'b0}}, ~(i_a ^ i_b)};
            default: w_illegalOp = 1'b1;
        endcase
    end

    assign w_divZero = w_isDiv && (i_b == '0);
    assign w_accept  = i_in_valid && (r_state == IDLE);
    assign w_load    = w_accept && w_isIter && !w_divZero;
    assign w_step    = (r_state == ITER);

    alu_iter_core #(.W(W)) u_iterCore (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_load),
        .i_step     (w_step),
        .i_isDiv    (w_isDiv),
        .i_a        (i_a),
        .i_b        (i_b),
        .o_finished (w_finished),
        .o_result   (w_iterResult)
    );

    // Controller with registered handshake outputs. in_ready only returns
    // after the HOLD->IDLE edge, so accept and consume never coincide.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_inReady  <= 1'b1;
            r_outValid <= 1'b0;
            r_out      <= '0;
            r_divZero  <= 1'b0;
            r_illegal  <= 1'b0;
            r_isMod    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_in_valid) begin
                        r_inReady <= 1'b0;
                        r_isMod   <= w_isMod;
                        if (w_isIter && !w_divZero) begin
                            r_state <= ITER;
                        end else begin
                            r_state    <= HOLD;
                            r_outValid <= 1'b1;
                            r_out      <= w_single;
                            r_divZero  <= w_divZero;
                            r_illegal  <= w_illegalOp;
                        end
                    end
                end
                ITER: begin
                    if (w_finished) begin
                        r_state    <= HOLD;
                        r_outValid <= 1'b1;
                        r_out      <= r_isMod ? {{W{1'b0}}, w_iterResult[2*W-1:W]}
                                              : w_iterResult;
                        r_divZero  <= 1'b0;
                        r_illegal  <= 1'b0;
                    end
                end
                HOLD: begin
                    if (i_out_ready) begin
                        r_state    <= IDLE;
                        r_outValid <= 1'b0;
                        r_inReady  <= 1'b1;
                    end
                end
                default: begin
                    r_state    <= IDLE;
                    r_outValid <= 1'b0;
                    r_inReady  <= 1'b1;
                end
            endcase
        end
    end

    assign o_in_ready  = r_inReady;
    assign o_out_valid = r_outValid;
    assign o_out       = r_out;
    assign o_div_zero  = r_divZero;
    assign o_illegal   = r_illegal;

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq
//   Directed bench for alu_seq at W=32. Expected values are hand-computed
//   constants; latency is counted in falling edges after the accept edge.
module tb_alu_seq;

    localparam int W = 32;

    logic           clk;
    logic           rstN;
    logic           inValid;
    logic           inReady;
    logic [W-1:0]   aIn;
    logic [W-1:0]   bIn;
    logic [3:0]     selIn;
    logic           outValid;
    logic           outReady;
    logic [2*W-1:0] outData;
    logic           divZero;
    logic           illegal;

    int testsRun;
    int testsFailed;

    alu_seq #(.W(W)) dut (
        .clk         (clk),
        .rst_n       (rstN),
        .i_in_valid  (inValid),
        .o_in_ready  (inReady),
        .i_a         (aIn),
        .i_b         (bIn),
        .i_sel       (selIn),
        .o_out_valid (outValid),
        .i_out_ready (outReady),
        .o_out       (outData),
        .o_div_zero  (divZero),
        .o_illegal   (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Every comparison funnels through here so the counts stay honest.
    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%h, expected 0x%h", tag, observed, expected);
        end
    endtask

    // Issue one request from a falling edge, scramble the operands right
    // after the accept edge, and return at the first falling edge that
    // shows out_valid, with the latency in falling edges.
    task automatic applyStimulus(input logic [3:0] sel, input logic [W-1:0] a,
                                 input logic [W-1:0] b, output int lat);
        int guard;
        guard = 0;
        while (!inReady && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (!inReady) checkOutput("acceptTimeout", 64'(inReady), 64'd1);
        selIn   = sel;
        aIn     = a;
        bIn     = b;
        inValid = 1'b1;
        @(posedge clk);
        #1;
        inValid = 1'b0;
        aIn     = ~a;
        bIn     = ~b;
        selIn   = 4'b0000;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!outValid && lat < 100);
        if (!outValid) checkOutput("resultTimeout", 64'(outValid), 64'd1);
    endtask

    logic [3:0]  logicSel [8] = '{4'b1000, 4'b1001, 4'b1010, 4'b1011,
                                  4'b1100, 4'b1101, 4'b1110, 4'b1111};
    logic [63:0] logicExp [8] = '{64'h0000_0000_0000_0030, 64'h0000_0000_0000_14FE,
                                  64'h0000_0000_0000_14CE, 64'h0000_0000_FFFF_EB41,
                                  64'h0000_0000_FFFF_FF8F, 64'h0000_0000_FFFF_FFCF,
                                  64'h0000_0000_FFFF_EB01, 64'h0000_0000_FFFF_EB31};

    initial begin
        int lat;
        logic sawValid;
        testsRun    = 0;
        testsFailed = 0;
        rstN     = 1'b0;
        inValid  = 1'b0;
        outReady = 1'b0;
        aIn      = '0;
        bIn      = '0;
        selIn    = '0;

        repeat (3) @(negedge clk);
        checkOutput("resetOutValid", 64'(outValid), 64'd0);
        checkOutput("resetInReady",  64'(inReady),  64'd1);
        checkOutput("resetOut",      outData,       64'd0);
        checkOutput("resetDivZero",  64'(divZero),  64'd0);
        checkOutput("resetIllegal",  64'(illegal),  64'd0);
        rstN = 1'b1;
        @(negedge clk);

        // Back-to-back arithmetic with the consumer always ready.
        outReady = 1'b1;
        applyStimulus(4'b0000, 32'd5310, 32'd112, lat);
        checkOutput("addOut", outData, 64'd5422);
        checkOutput("addLatency", 64'(lat), 64'd1);
        checkOutput("addInReadyInHold", 64'(inReady), 64'd0);

        applyStimulus(4'b0001, 32'd5310, 32'd112, lat);
        checkOutput("subOut", outData, 64'd5198);

        applyStimulus(4'b0010, 32'd5310, 32'd112, lat);
        checkOutput("mulOut", outData, 64'd594720);
        checkOutput("mulLatency", 64'(lat), 64'd33);

        applyStimulus(4'b0011, 32'd5310, 32'd112, lat);
        checkOutput("divOut", outData, {32'd46, 32'd47});
        checkOutput("divLatency", 64'(lat), 64'd33);
        checkOutput("divNoDivZero", 64'(divZero), 64'd0);

        applyStimulus(4'b0100, 32'd5310, 32'd112, lat);
        checkOutput("modOut", outData, 64'd46);

        applyStimulus(4'b0001, 32'd112, 32'd5310, lat);
        checkOutput("subNegative", outData, 64'hFFFF_FFFF_FFFF_EBB2);

        applyStimulus(4'b0010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat);
        checkOutput("mulMax", outData, 64'hFFFF_FFFE_0000_0001);

        // Logic group and unused opcodes.
        for (int i = 0; i < 8; i++) begin
            applyStimulus(logicSel[i], 32'd5310, 32'd112, lat);
            checkOutput($sformatf("logic%b", logicSel[i]), outData, logicExp[i]);
            checkOutput($sformatf("logicIllegal%b", logicSel[i]), 64'(illegal), 64'd0);
        end
        for (int i = 5; i < 8; i++) begin
            applyStimulus(4'(i), 32'd5310, 32'd112, lat);
            checkOutput($sformatf("illegalOut%0d", i), outData, 64'd0);
            checkOutput($sformatf("illegalFlag%0d", i), 64'(illegal), 64'd1);
        end

        // Divide and modulo by zero.
        applyStimulus(4'b0011, 32'd7, 32'd0, lat);
        checkOutput("divZeroOut", outData, {32'd7, 32'hFFFF_FFFF});
        checkOutput("divZeroFlag", 64'(divZero), 64'd1);
        checkOutput("divZeroLatency", 64'(lat), 64'd1);

        applyStimulus(4'b0100, 32'd7, 32'd0, lat);
        checkOutput("modZeroOut", outData, 64'd7);
        checkOutput("modZeroFlag", 64'(divZero), 64'd1);
        checkOutput("modZeroLatency", 64'(lat), 64'd1);

        applyStimulus(4'b0000, 32'd1, 32'd2, lat);
        checkOutput("flagsClearedOut", outData, 64'd3);
        checkOutput("flagsClearedDivZero", 64'(divZero), 64'd0);

        // Back-pressure: result must stay put and new requests be ignored.
        @(negedge clk);
        outReady = 1'b0;
        applyStimulus(4'b0011, 32'd7, 32'd0, lat);
        checkOutput("holdFirstOut", outData, {32'd7, 32'hFFFF_FFFF});
        selIn   = 4'b0000;
        aIn     = 32'd1;
        bIn     = 32'd1;
        inValid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput($sformatf("holdOut%0d", i), outData, {32'd7, 32'hFFFF_FFFF});
            checkOutput($sformatf("holdValid%0d", i), 64'(outValid), 64'd1);
            checkOutput($sformatf("holdInReady%0d", i), 64'(inReady), 64'd0);
            checkOutput($sformatf("holdDivZero%0d", i), 64'(divZero), 64'd1);
        end
        inValid  = 1'b0;
        outReady = 1'b1;
        @(negedge clk);
        checkOutput("consumedValid", 64'(outValid), 64'd0);
        checkOutput("consumedInReady", 64'(inReady), 64'd1);
        outReady = 1'b0;

        // Reset in the middle of a multiply.
        selIn   = 4'b0010;
        aIn     = 32'd5310;
        bIn     = 32'd112;
        inValid = 1'b1;
        @(posedge clk);
        #1;
        inValid = 1'b0;
        repeat (10) @(negedge clk);
        checkOutput("midIterInReady", 64'(inReady), 64'd0);
        checkOutput("midIterValid", 64'(outValid), 64'd0);
        #2;
        rstN = 1'b0;
        #1;
        checkOutput("abortOut", outData, 64'd0);
        checkOutput("abortValid", 64'(outValid), 64'd0);
        checkOutput("abortInReady", 64'(inReady), 64'd1);
        checkOutput("abortDivZero", 64'(divZero), 64'd0);
        checkOutput("abortIllegal", 64'(illegal), 64'd0);
        @(negedge clk);
        rstN     = 1'b1;
        outReady = 1'b1;
        sawValid = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (outValid) sawValid = 1'b1;
        end
        checkOutput("noResultAfterAbort", 64'(sawValid), 64'd0);
        checkOutput("idleAfterAbort", 64'(inReady), 64'd1);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation still running at time %0t, required to finish earlier", $time);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
